// File: rtl/data_memory_bank.sv
// Single-port data memory for the load/store path: valid/ready requests, byte strobes,
// read-first stores, out-of-range flagging, 1/2-cycle read latency and a zero-fill sequencer.
module data_memory_bank #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  input  logic                    clear,
  output logic                    busy
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic                  clear_last;
  logic                  s1_valid;
  logic                  s1_err;
  logic [DATA_WIDTH-1:0] s1_rdata;

  assign req_ready  = (state == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign in_range   = {1'b0, req_addr} < CW'(DEPTH);
  assign clear_last = cnt == CW'(DEPTH - 1);
  assign busy       = state == CLEAR;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clear) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt + CW'(1);
        if (clear_last) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The array has no reset; rst only blocks writes so an aborted clear leaves the rest intact.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt[ADDR_WIDTH-1:0]] <= '0;
      end else if (accept && req_write && in_range) begin
        for (int i = 0; i < LANES; i++) begin
          if (req_wstrb[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_rdata <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_err   <= !in_range;
        s1_rdata <= in_range ? mem[req_addr] : '0;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid;
      logic                  s2_err;
      logic [DATA_WIDTH-1:0] s2_rdata;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_rdata <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_err   <= s1_err;
            s2_rdata <= s1_rdata;
          end
        end
      end

      assign rsp_valid = s2_valid;
      assign rsp_err   = s2_err;
      assign rsp_rdata = s2_rdata;
    end else begin : g_lat1
      assign rsp_valid = s1_valid;
      assign rsp_err   = s1_err;
      assign rsp_rdata = s1_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_data_memory_bank.sv
// Self-checking bench: one 16-word/1-cycle and one 12-word/2-cycle instance share the
// same directed stimulus and are compared every cycle against an array/queue model.
module tb_data_memory_bank;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int LN = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [LN-1:0] req_wstrb = '0;

  logic          ready_a, rsp_valid_a, err_a, busy_a;
  logic [DW-1:0] rdata_a;
  logic          ready_b, rsp_valid_b, err_b, busy_b;
  logic [DW-1:0] rdata_b;

  always #5 clk = ~clk;

  data_memory_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(16), .READ_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid_a),
    .rsp_rdata(rdata_a), .rsp_err(err_a), .clear(clear), .busy(busy_a)
  );

  data_memory_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(12), .READ_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rdata_b), .rsp_err(err_b), .clear(clear), .busy(busy_b)
  );

  typedef struct {int due; logic [31:0] rdata; logic err;} exp_t;
  typedef struct {int cyc; logic [31:0] rdata; logic err;} obs_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t eq0[$], eq1[$];
  obs_t obs0[$], obs1[$];
  logic [31:0] mdl_mem [2][16];
  int   clear_left [2] = '{0, 0};
  int   clr_cnt [2] = '{0, 0};

  function automatic int dep(int k); return (k == 0) ? 16 : 12; endfunction
  function automatic int lat(int k); return (k == 0) ? 1 : 2; endfunction
  function automatic logic [31:0] fill(int a);
    return 32'h1000_0001 + 32'(a) * 32'h0101_0101;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: a request is served whenever no clear is running; the clear then zeroes one word per cycle.
  task automatic modelStep(int k);
    exp_t r;
    int   a;
    a = int'(req_addr);
    if (clear_left[k] == 0 && req_valid) begin
      r.due = cyc + lat(k) - 1;
      if (a < dep(k)) begin
        r.rdata = mdl_mem[k][a];
        r.err   = 1'b0;
        if (req_write)
          for (int i = 0; i < LN; i++)
            if (req_wstrb[i]) mdl_mem[k][a][8*i +: 8] = req_wdata[8*i +: 8];
      end else begin
        r.rdata = '0;
        r.err   = 1'b1;
      end
      if (k == 0) eq0.push_back(r); else eq1.push_back(r);
    end
    if (clear_left[k] > 0) begin
      mdl_mem[k][clr_cnt[k]] = '0;
      clr_cnt[k]++;
      clear_left[k]--;
    end else if (clear) begin
      clear_left[k] = dep(k);
      clr_cnt[k]    = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_left[0] = 0;
      clear_left[1] = 0;
      eq0.delete();
      eq1.delete();
    end else begin
      cyc++;
      modelStep(0);
      modelStep(1);
    end
  end

  task automatic cmpInst(int k, logic rv, logic [31:0] rd, logic er, logic rdy, logic bz);
    exp_t e;
    obs_t o;
    logic ev;
    ev = 1'b0;
    if (k == 0) begin
      if (eq0.size() > 0 && eq0[0].due == cyc) begin e = eq0.pop_front(); ev = 1'b1; end
    end else begin
      if (eq1.size() > 0 && eq1[0].due == cyc) begin e = eq1.pop_front(); ev = 1'b1; end
    end
    checkOutput($sformatf("rsp_valid[%0d] cyc %0d", k, cyc), 64'(rv), 64'(ev));
    if (ev && rv) begin
      checkOutput($sformatf("rsp_rdata[%0d] cyc %0d", k, cyc), 64'(rd), 64'(e.rdata));
      checkOutput($sformatf("rsp_err[%0d] cyc %0d", k, cyc), 64'(er), 64'(e.err));
    end
    checkOutput($sformatf("req_ready[%0d] cyc %0d", k, cyc), 64'(rdy), 64'(!rst && clear_left[k] == 0));
    checkOutput($sformatf("busy[%0d] cyc %0d", k, cyc), 64'(bz), 64'(clear_left[k] > 0));
    if (rst) begin
      checkOutput($sformatf("rsp_rdata_rst[%0d]", k), 64'(rd), 64'(0));
      checkOutput($sformatf("rsp_err_rst[%0d]", k), 64'(er), 64'(0));
    end
    if (rv) begin
      o.cyc = cyc; o.rdata = rd; o.err = er;
      if (k == 0) obs0.push_back(o); else obs1.push_back(o);
    end
  endtask

  always @(negedge clk) begin
    cmpInst(0, rsp_valid_a, rdata_a, err_a, ready_a, busy_a);
    cmpInst(1, rsp_valid_b, rdata_b, err_b, ready_b, busy_b);
  end

  task automatic applyStimulus(logic v, logic w, int a, logic [31:0] d, logic [3:0] s, logic c);
    @(posedge clk);
    #1;
    req_valid = v;
    req_write = w;
    req_addr  = AW'(a);
    req_wdata = d;
    req_wstrb = s;
    clear     = c;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic fillAll();
    for (int a = 0; a < 16; a++) applyStimulus(1'b1, 1'b1, a, fill(a), 4'hF, 1'b0);
    idle(4);
  endtask

  task automatic loadSweep();
    for (int a = 0; a < 16; a++) applyStimulus(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0);
    idle(4);
  endtask

  initial begin
    int c0;
    int na;
    int nb;

    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 64'({ready_a, ready_b}), 64'(2'b11));

    // Mid-cycle asynchronous reset pulse while idle.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_ready", 64'({ready_a, ready_b}), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    applyStimulus(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b1);
    idle(20);
    fillAll();

    obs0.delete(); obs1.delete();
    applyStimulus(1'b1, 1'b1, 3, 32'hDEADBEEF, 4'hF, 1'b0);
    applyStimulus(1'b1, 1'b0, 3, 32'h0, 4'h0, 1'b0);
    idle(5);
    checkOutput("store_load_count", 64'(obs0.size()), 64'(2));
    if (obs0.size() >= 2) begin
      checkOutput("store_prior_word", 64'(obs0[0].rdata), 64'(fill(3)));
      checkOutput("load_new_word", 64'({obs0[1].err, obs0[1].rdata}), 64'({1'b0, 32'hDEADBEEF}));
      checkOutput("back_to_back_spacing", 64'(obs0[1].cyc - obs0[0].cyc), 64'(1));
    end

    obs0.delete(); obs1.delete();
    applyStimulus(1'b1, 1'b1, 5, 32'h11223344, 4'hF, 1'b0);
    applyStimulus(1'b1, 1'b1, 5, 32'hAABBCCDD, 4'b0101, 1'b0);
    applyStimulus(1'b1, 1'b0, 5, 32'h0, 4'h0, 1'b0);
    idle(5);
    checkOutput("strobe_count_b", 64'(obs1.size()), 64'(3));
    if (obs0.size() >= 3) checkOutput("strobe_merge_a", 64'(obs0[2].rdata), 64'(32'h11BB33DD));
    if (obs1.size() >= 3) checkOutput("strobe_merge_b", 64'(obs1[2].rdata), 64'(32'h11BB33DD));

    obs0.delete(); obs1.delete();
    applyStimulus(1'b1, 1'b1, 13, 32'hFFFFFFFF, 4'hF, 1'b0);
    applyStimulus(1'b1, 1'b0, 13, 32'h0, 4'h0, 1'b0);
    idle(5);
    checkOutput("oor_count_b", 64'(obs1.size()), 64'(2));
    if (obs1.size() >= 2) begin
      checkOutput("oor_store_b", 64'({obs1[0].err, obs1[0].rdata}), 64'({1'b1, 32'h0}));
      checkOutput("oor_load_b", 64'({obs1[1].err, obs1[1].rdata}), 64'({1'b1, 32'h0}));
    end
    if (obs0.size() >= 2) checkOutput("inrange_load_a", 64'({obs0[1].err, obs0[1].rdata}), 64'({1'b0, 32'hFFFFFFFF}));
    loadSweep();

    obs0.delete(); obs1.delete();
    applyStimulus(1'b1, 1'b0, 0, 32'h0, 4'h0, 1'b0);
    c0 = cyc;
    for (int a = 1; a < 4; a++) applyStimulus(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0);
    idle(5);
    checkOutput("stream_count_b", 64'(obs1.size()), 64'(4));
    if (obs0.size() >= 1) checkOutput("lat1_first", 64'(obs0[0].cyc), 64'(c0 + 1));
    if (obs1.size() >= 4) begin
      checkOutput("lat2_first", 64'(obs1[0].cyc), 64'(c0 + 2));
      checkOutput("lat2_last", 64'(obs1[3].cyc), 64'(c0 + 5));
      checkOutput("lat2_data0", 64'(obs1[0].rdata), 64'(fill(0)));
      checkOutput("lat2_data3", 64'(obs1[3].rdata), 64'(32'hDEADBEEF));
    end

    fillAll();
    obs0.delete(); obs1.delete();
    applyStimulus(1'b1, 1'b1, 0, 32'h5, 4'hF, 1'b1);
    idle(1);
    na = 0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_a) na++;
      if (busy_b) nb++;
    end
    checkOutput("clear_busy_cycles_a", 64'(na), 64'(16));
    checkOutput("clear_busy_cycles_b", 64'(nb), 64'(12));
    loadSweep();
    checkOutput("clear_count_a", 64'(obs0.size()), 64'(17));
    if (obs0.size() >= 17) begin
      checkOutput("collision_store_ack", 64'(obs0[0].rdata), 64'(fill(0)));
      checkOutput("cleared_word0", 64'(obs0[1].rdata), 64'(0));
      checkOutput("cleared_word15", 64'(obs0[16].rdata), 64'(0));
    end

    fillAll();
    applyStimulus(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    obs0.delete(); obs1.delete();
    loadSweep();
    if (obs0.size() >= 16) begin
      checkOutput("abort_word5_a", 64'(obs0[5].rdata), 64'(0));
      checkOutput("abort_word6_a", 64'(obs0[6].rdata), 64'(fill(6)));
      checkOutput("abort_word15_a", 64'(obs0[15].rdata), 64'(fill(15)));
    end else begin
      checkOutput("abort_count_a", 64'(obs0.size()), 64'(16));
    end
    if (obs1.size() >= 7) checkOutput("abort_word6_b", 64'(obs1[6].rdata), 64'(fill(6)));

    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
